// File: rtl/xor_bit_packer.sv
// xor_bit_packer: packs an en/rdy bit stream LSB-first into WIDTH-bit words
// and queues {word, len, ones} in a DEPTH-entry FIFO for a wide en/rdy sink.
//
// Ports:
//   CLK, RST_N          clock, async active-low reset
//   in_data/in_en/in_rdy  bit-serial input handshake
//   flush               emit the current partial word (held until honoured)
//   out_data/out_len/out_ones  head word, its valid bits and ones count
//   out_en/out_rdy      word output handshake (out_en = FIFO non-empty)
//   count               words currently buffered
module xor_bit_packer #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       CLK,
    input  logic                       RST_N,
    input  logic                       in_data,
    input  logic                       in_en,
    output logic                       in_rdy,
    input  logic                       flush,
    output logic [WIDTH-1:0]           out_data,
    output logic [$clog2(WIDTH):0]     out_len,
    output logic [$clog2(WIDTH):0]     out_ones,
    output logic                       out_en,
    input  logic                       out_rdy,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int LW = $clog2(WIDTH) + 1;
    localparam int CW = $clog2(DEPTH) + 1;
    localparam int PW = $clog2(DEPTH);

    localparam logic [LW-1:0] LAST  = LW'(WIDTH - 1);
    localparam logic [CW-1:0] FULLV = CW'(DEPTH);

    logic [LW-1:0]    bit_cnt;
    logic [LW-1:0]    ones;
    logic [WIDTH-1:0] shreg;
    logic [PW-1:0]    head;
    logic [PW-1:0]    tail;

    logic [WIDTH-1:0] mem_data [DEPTH];
    logic [LW-1:0]    mem_len  [DEPTH];
    logic [LW-1:0]    mem_ones [DEPTH];

    logic             full;
    logic             empty;
    logic             acc;
    logic             complete;
    logic             fl_push;
    logic             push;
    logic             pop;
    logic [WIDTH-1:0] bit_mask;
    logic [WIDTH-1:0] nxt_word;
    logic [LW-1:0]    nxt_cnt;
    logic [LW-1:0]    nxt_ones;

    always_comb begin
        full     = (count == FULLV);
        empty    = (count == '0);
        // Only the last bit of a word needs FIFO space; earlier bits
        // are always absorbed by the shift register.
        in_rdy   = !(bit_cnt == LAST && full);
        acc      = in_en && in_rdy;
        bit_mask = WIDTH'(1) << bit_cnt;
        nxt_word = (acc && in_data) ? (shreg | bit_mask) : shreg;
        nxt_cnt  = bit_cnt + LW'(acc);
        nxt_ones = ones + LW'(acc && in_data);
        complete = acc && (bit_cnt == LAST);
        // A full word already pushes this edge, so flush adds nothing.
        fl_push  = flush && !complete && (nxt_cnt != '0) && !full;
        push     = complete || fl_push;
        pop      = !empty && out_rdy;
    end

    // Storage is not reset; empty entries are masked at the output.
    always_ff @(posedge CLK) begin
        if (push) begin
            mem_data[tail] <= nxt_word;
            mem_len[tail]  <= nxt_cnt;
            mem_ones[tail] <= nxt_ones;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            bit_cnt <= '0;
            ones    <= '0;
            shreg   <= '0;
            head    <= '0;
            tail    <= '0;
            count   <= '0;
        end else begin
            if (push) begin
                bit_cnt <= '0;
                ones    <= '0;
                shreg   <= '0;
                tail    <= tail + 1'b1;
            end else begin
                bit_cnt <= nxt_cnt;
                ones    <= nxt_ones;
                shreg   <= nxt_word;
            end
            if (pop) begin
                head <= head + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_comb begin
        out_en   = !empty;
        out_data = empty ? '0 : mem_data[head];
        out_len  = empty ? '0 : mem_len[head];
        out_ones = empty ? '0 : mem_ones[head];
    end

endmodule

// File: tb/tb_xor_bit_packer.sv
// tb_xor_bit_packer: scoreboard bench for xor_bit_packer.
// Directed scenarios plus randomized traffic against a bit-queue model.
module tb_xor_bit_packer;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;

    logic                   CLK = 1'b0;
    logic                   RST_N;
    logic                   in_data;
    logic                   in_en;
    logic                   in_rdy;
    logic                   flush;
    logic [WIDTH-1:0]       out_data;
    logic [$clog2(WIDTH):0] out_len;
    logic [$clog2(WIDTH):0] out_ones;
    logic                   out_en;
    logic                   out_rdy;
    logic [$clog2(DEPTH):0] count;

    xor_bit_packer #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RST_N(RST_N),
        .in_data(in_data), .in_en(in_en), .in_rdy(in_rdy),
        .flush(flush),
        .out_data(out_data), .out_len(out_len), .out_ones(out_ones),
        .out_en(out_en), .out_rdy(out_rdy), .count(count)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        int data;
        int len;
        int ones;
    } exp_t;

    exp_t exp_q[$];
    bit   bits[$];
    int   m_cnt;
    int   n_vec;
    int   n_err;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    // Word value from the spec's rules: bit i of the word is the i-th
    // accepted bit, upper bits zero.
    task automatic emit();
        exp_t e;
        e.data = 0;
        e.ones = 0;
        e.len  = bits.size();
        foreach (bits[i]) begin
            e.data += int'(bits[i]) * (1 << i);
            e.ones += int'(bits[i]);
        end
        exp_q.push_back(e);
        bits.delete();
    endtask

    // Called at posedge+1; inputs held for one full cycle.
    task automatic cyc(input logic d, input logic en, input logic fl,
                       input logic ordy);
        bit full;
        bit rdy;
        bit pop;
        bit done;
        in_data = d;
        in_en   = en;
        flush   = fl;
        out_rdy = ordy;
        @(negedge CLK);
        full = (m_cnt == DEPTH);
        rdy  = !(bits.size() == WIDTH - 1 && full);
        chk("in_rdy", 32'(in_rdy), 32'(rdy));
        chk("count", 32'(count), m_cnt);
        chk("out_en", 32'(out_en), 32'(m_cnt != 0));
        pop  = (m_cnt != 0) && ordy;
        done = 0;
        if (en && rdy) begin
            bits.push_back(d);
            if (bits.size() == WIDTH) begin
                emit();
                done = 1;
            end
        end
        if (!done && fl && bits.size() != 0 && !full) begin
            emit();
            done = 1;
        end
        m_cnt = m_cnt + int'(done) - int'(pop);
        @(posedge CLK);
        #1;
    endtask

    task automatic peek(input int d, input int l, input int o);
        chk("peek_data", 32'(out_data), d);
        chk("peek_len", 32'(out_len), l);
        chk("peek_ones", 32'(out_ones), o);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 1; i++) cyc(0, 0, 0, 1);
    endtask

    task automatic do_reset();
        RST_N   = 1'b0;
        in_en   = 1'b0;
        flush   = 1'b0;
        out_rdy = 1'b0;
        #1;
        chk("rst_in_rdy", 32'(in_rdy), 1);
        chk("rst_out_en", 32'(out_en), 0);
        chk("rst_count", 32'(count), 0);
        chk("rst_out_data", 32'(out_data), 0);
        bits.delete();
        exp_q.delete();
        m_cnt = 0;
        @(posedge CLK);
        #1;
        RST_N = 1'b1;
    endtask

    // Monitor: pops the scoreboard whenever the sink takes a word.
    always @(negedge CLK) begin
        if (RST_N) begin
            if (out_en && out_rdy) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_word", 32'(out_data), 32'hffff_ffff);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    chk("out_data", 32'(out_data), e.data);
                    chk("out_len", 32'(out_len), e.len);
                    chk("out_ones", 32'(out_ones), e.ones);
                end
            end else if (!out_en) begin
                chk("idle_zero", 32'({out_data, out_len, out_ones}), 0);
            end
        end
    end

    initial begin
        logic [7:0] pat;
        n_vec   = 0;
        n_err   = 0;
        m_cnt   = 0;
        RST_N   = 1'b1;
        in_data = 1'b0;
        in_en   = 1'b0;
        flush   = 1'b0;
        out_rdy = 1'b0;
        @(posedge CLK);
        #1;
        do_reset();

        // Pack 1,0,1,1,0,0,0,1 -> 0x8D
        pat = 8'h8D;
        for (int i = 0; i < 8; i++) cyc(pat[i], 1, 0, 1);
        peek(32'h8D, 8, 4);
        cyc(0, 0, 0, 1);
        chk("pack_count", 32'(count), 0);

        // Full / backpressure with 39 bits
        for (int i = 0; i < 39; i++) cyc(1, 1, 0, 0);
        chk("full_count", 32'(count), 4);
        chk("full_in_rdy", 32'(in_rdy), 0);
        cyc(1, 1, 0, 1);
        chk("after_pop_count", 32'(count), 3);
        chk("after_pop_rdy", 32'(in_rdy), 1);
        cyc(0, 1, 0, 0);
        chk("refill_count", 32'(count), 4);
        drain();

        // Flush partial 1,1,0
        cyc(1, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(0, 0, 1, 0);
        peek(3, 3, 2);
        drain();
        cyc(0, 0, 1, 0);
        chk("flush_empty_count", 32'(count), 0);

        // Flush while full is ignored until a pop
        for (int i = 0; i < 34; i++) cyc(i[0], 1, 0, 0);
        for (int i = 0; i < 3; i++) cyc(0, 0, 1, 0);
        chk("flush_full_count", 32'(count), 4);
        cyc(0, 0, 1, 1);
        cyc(0, 0, 1, 0);
        chk("flush_after_pop", 32'(count), 4);
        drain();

        // Flush coincident with an accepted bit
        cyc(1, 1, 0, 0);
        cyc(0, 1, 0, 0);
        cyc(1, 1, 1, 0);
        peek(5, 3, 2);
        drain();

        // Reset mid-stream discards partial bits
        for (int i = 0; i < 5; i++) cyc(1, 1, 0, 0);
        do_reset();
        cyc(0, 1, 0, 0);
        cyc(1, 1, 0, 0);
        cyc(0, 0, 1, 0);
        peek(2, 2, 1);
        drain();

        // Randomized traffic, including push/pop overlap and wrap
        for (int i = 0; i < 1500; i++) begin
            if (i == 700) do_reset();
            cyc(1'($urandom_range(0, 1)),
                1'($urandom_range(0, 9) < 7),
                1'($urandom_range(0, 19) == 0),
                1'($urandom_range(0, 1)));
        end
        drain();
        cyc(0, 0, 1, 1);
        drain();
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
